// File: rtl/l1tlb_l2req_arb.sv
// L1 TLB -> L2 TLB request arbiter: two per-source FIFOs, round-robin grant,
// registered output stage with source tag. Optional stats: TLB_ARB_STATS_EN.

module l1tlb_l2req_fifo #(
    parameter int REQ_W = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    input  logic [REQ_W-1:0] din,
    input  logic             pop,
    output logic             retry,
    output logic             empty,
    output logic [REQ_W-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [REQ_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             push;

    // Retry is a flop, so a full FIFO refuses the write outright.
    assign push  = push_valid && !retry;
    assign empty = (cnt == '0);
    assign dout  = mem[rptr];

    // Next occupancy; push and pop together leave it unchanged.
    always_comb begin
        cnt_nxt = cnt;
        unique case ({push, pop})
            2'b10:   cnt_nxt = cnt + CW'(1);
            2'b01:   cnt_nxt = cnt - CW'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    // Pointers, count and registered full flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            retry <= 1'b0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            cnt   <= cnt_nxt;
            retry <= (cnt_nxt == CW'(DEPTH));
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end
endmodule

module l1tlb_l2req_arb #(
    parameter int REQ_W = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dctlb_req_valid,
    output logic             dctlb_req_retry,
    input  logic [REQ_W-1:0] dctlb_req,
    input  logic             ictlb_req_valid,
    output logic             ictlb_req_retry,
    input  logic [REQ_W-1:0] ictlb_req,
    output logic             l1tlbtol2tlb_req_valid,
    input  logic             l1tlbtol2tlb_req_retry,
    output logic [REQ_W-1:0] l1tlbtol2tlb_req,
    output logic             l1tlbtol2tlb_req_src
`ifdef TLB_ARB_STATS_EN
    ,
    output logic [15:0]      dctlb_grant_cnt,
    output logic [15:0]      ictlb_grant_cnt
`endif
);
    logic             d_empty;
    logic             i_empty;
    logic [REQ_W-1:0] d_dout;
    logic [REQ_W-1:0] i_dout;
    logic             load;
    logic             grant_d;
    logic             grant_i;
    logic             last_grant;

    l1tlb_l2req_fifo #(.REQ_W(REQ_W), .DEPTH(DEPTH)) u_dfifo (
        .clk        (clk),
        .reset      (reset),
        .push_valid (dctlb_req_valid),
        .din        (dctlb_req),
        .pop        (grant_d),
        .retry      (dctlb_req_retry),
        .empty      (d_empty),
        .dout       (d_dout)
    );

    l1tlb_l2req_fifo #(.REQ_W(REQ_W), .DEPTH(DEPTH)) u_ififo (
        .clk        (clk),
        .reset      (reset),
        .push_valid (ictlb_req_valid),
        .din        (ictlb_req),
        .pop        (grant_i),
        .retry      (ictlb_req_retry),
        .empty      (i_empty),
        .dout       (i_dout)
    );

    // Output slot is free when empty or its contents leave this edge.
    assign load = !l1tlbtol2tlb_req_valid || !l1tlbtol2tlb_req_retry;

    // Round-robin pick; a tie goes to the source not granted last.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (load) begin
            unique case ({!d_empty, !i_empty})
                2'b11: begin
                    grant_d = last_grant;
                    grant_i = !last_grant;
                end
                2'b10:   grant_d = 1'b1;
                2'b01:   grant_i = 1'b1;
                default: ;
            endcase
        end
    end

    // Registered output stage and grant history.
    always_ff @(posedge clk) begin
        if (!reset) begin
            l1tlbtol2tlb_req_valid <= 1'b0;
            l1tlbtol2tlb_req       <= '0;
            l1tlbtol2tlb_req_src   <= 1'b0;
            last_grant             <= 1'b1;
        end else if (load) begin
            if (grant_d) begin
                l1tlbtol2tlb_req_valid <= 1'b1;
                l1tlbtol2tlb_req       <= d_dout;
                l1tlbtol2tlb_req_src   <= 1'b0;
                last_grant             <= 1'b0;
            end else if (grant_i) begin
                l1tlbtol2tlb_req_valid <= 1'b1;
                l1tlbtol2tlb_req       <= i_dout;
                l1tlbtol2tlb_req_src   <= 1'b1;
                last_grant             <= 1'b1;
            end else begin
                l1tlbtol2tlb_req_valid <= 1'b0;
            end
        end
    end

`ifdef TLB_ARB_STATS_EN
    // Saturating per-source grant counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dctlb_grant_cnt <= '0;
            ictlb_grant_cnt <= '0;
        end else begin
            if (grant_d && dctlb_grant_cnt != 16'hFFFF)
                dctlb_grant_cnt <= dctlb_grant_cnt + 16'd1;
            if (grant_i && ictlb_grant_cnt != 16'hFFFF)
                ictlb_grant_cnt <= ictlb_grant_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_l1tlb_l2req_arb.sv
// Directed self-checking bench for l1tlb_l2req_arb.
// Stats test runs only when TLB_ARB_STATS_EN is defined.

module tb_l1tlb_l2req_arb;
    localparam int REQ_W = 64;
    localparam int DEPTH = 4;

    logic             clk;
    logic             reset;
    logic             dctlb_req_valid;
    logic             dctlb_req_retry;
    logic [REQ_W-1:0] dctlb_req;
    logic             ictlb_req_valid;
    logic             ictlb_req_retry;
    logic [REQ_W-1:0] ictlb_req;
    logic             l2_valid;
    logic             l2_retry;
    logic [REQ_W-1:0] l2_req;
    logic             l2_src;
`ifdef TLB_ARB_STATS_EN
    logic [15:0]      dctlb_grant_cnt;
    logic [15:0]      ictlb_grant_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    l1tlb_l2req_arb #(.REQ_W(REQ_W), .DEPTH(DEPTH)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .dctlb_req_valid        (dctlb_req_valid),
        .dctlb_req_retry        (dctlb_req_retry),
        .dctlb_req              (dctlb_req),
        .ictlb_req_valid        (ictlb_req_valid),
        .ictlb_req_retry        (ictlb_req_retry),
        .ictlb_req              (ictlb_req),
        .l1tlbtol2tlb_req_valid (l2_valid),
        .l1tlbtol2tlb_req_retry (l2_retry),
        .l1tlbtol2tlb_req       (l2_req),
        .l1tlbtol2tlb_req_src   (l2_src)
`ifdef TLB_ARB_STATS_EN
        ,
        .dctlb_grant_cnt        (dctlb_grant_cnt),
        .ictlb_grant_cnt        (ictlb_grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; drive and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dctlb_req_valid = 1'b0;
        dctlb_req       = '0;
        ictlb_req_valid = 1'b0;
        ictlb_req       = '0;
        l2_retry        = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        // Reset values
        chk("rst_dretry", dctlb_req_retry, 0);
        chk("rst_iretry", ictlb_req_retry, 0);
        chk("rst_valid", l2_valid, 0);
        chk("rst_req", l2_req, 0);
        chk("rst_src", l2_src, 0);
        reset = 1'b1;

        // Single dctlb request: visible after the second edge only
        dctlb_req_valid = 1'b1;
        dctlb_req       = 64'hA5;
        step();
        idle_inputs();
        chk("single_nobypass", l2_valid, 0);
        step();
        chk("single_valid", l2_valid, 1);
        chk("single_req", l2_req, 64'hA5);
        chk("single_src", l2_src, 0);
        step();
        chk("single_done", l2_valid, 0);

        // Single ictlb request tagged src=1
        ictlb_req_valid = 1'b1;
        ictlb_req       = 64'h5A;
        step();
        idle_inputs();
        step();
        chk("ionly", {l2_valid, l2_src, l2_req}, {1'b1, 1'b1, 64'h5A});
        step();

        // Round robin: both push 4, expect 0,1,0,1,...
        do_reset();
        for (int k = 0; k <= 8; k++) begin
            dctlb_req_valid = (k < 4);
            dctlb_req       = 64'h100 + 64'(k);
            ictlb_req_valid = (k < 4);
            ictlb_req       = 64'h200 + 64'(k);
            step();
            if (k >= 1) begin
                int j;
                logic exp_src;
                logic [63:0] exp_req;
                j       = k - 1;
                exp_src = j[0];
                exp_req = (exp_src ? 64'h200 : 64'h100) + 64'(j / 2);
                chk($sformatf("rr%0d", j), {l2_valid, l2_src, l2_req},
                    {1'b1, exp_src, exp_req});
            end
        end
        idle_inputs();
        step();
        chk("rr_done", l2_valid, 0);

        // Back-pressure: L2 stalled, dctlb pushes 5
        do_reset();
        l2_retry = 1'b1;
        for (int k = 0; k < 5; k++) begin
            dctlb_req_valid = 1'b1;
            dctlb_req       = 64'h300 + 64'(k);
            step();
            if (k == 3) chk("bp_notfull", dctlb_req_retry, 0);
        end
        chk("bp_full", dctlb_req_retry, 1);
        chk("bp_head", {l2_valid, l2_req}, {1'b1, 64'h300});
        // Offer a request while full: must be dropped
        dctlb_req = 64'hBAD;
        l2_retry  = 1'b0;
        step();
        dctlb_req_valid = 1'b0;
        chk("bp_retry_drop", dctlb_req_retry, 0);
        chk("bp_out1", {l2_valid, l2_req}, {1'b1, 64'h301});
        for (int k = 2; k < 5; k++) begin
            step();
            chk($sformatf("bp_out%0d", k), {l2_valid, l2_req},
                {1'b1, 64'h300 + 64'(k)});
        end
        step();
        chk("bp_done", l2_valid, 0);

        // Wrap-around: 3*DEPTH+1 requests one at a time
        do_reset();
        for (int k = 0; k < 3 * DEPTH + 1; k++) begin
            dctlb_req_valid = 1'b1;
            dctlb_req       = 64'h400 + 64'(k);
            step();
            dctlb_req_valid = 1'b0;
            step();
            chk($sformatf("wrap%0d", k), {l2_valid, l2_req},
                {1'b1, 64'h400 + 64'(k)});
            step();
        end

        // Reset mid-operation with 3 queued + 1 in output
        do_reset();
        l2_retry = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dctlb_req_valid = 1'b1;
            dctlb_req       = 64'h500 + 64'(k);
            step();
        end
        chk("mr_pre", {l2_valid, l2_req}, {1'b1, 64'h500});
        dctlb_req = 64'hBEEF;
        reset     = 1'b0;
        step();
        chk("mr_valid", l2_valid, 0);
        chk("mr_dretry", dctlb_req_retry, 0);
        chk("mr_iretry", ictlb_req_retry, 0);
        chk("mr_req", l2_req, 0);
        reset = 1'b1;
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("mr_stale%0d", k), l2_valid, 0);
        end

`ifdef TLB_ARB_STATS_EN
        // Stats: ictlb counter saturates, dctlb stays 0
        do_reset();
        step();
        chk("st_rst_d", dctlb_grant_cnt, 0);
        chk("st_rst_i", ictlb_grant_cnt, 0);
        ictlb_req_valid = 1'b1;
        ictlb_req       = 64'h77;
        for (int k = 0; k < 70000; k++) step();
        chk("st_isat", ictlb_grant_cnt, 16'hFFFF);
        chk("st_dzero", dctlb_grant_cnt, 0);
        idle_inputs();
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
